// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm-set controller.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } state_t;

  localparam logic [4:0] MAX_HOURS         = 5'd23;
  localparam logic [5:0] MAX_MINUTES       = 6'd59;
  localparam logic [4:0] RST_ALARM_HOURS   = 5'd6;
  localparam logic [5:0] RST_ALARM_MINUTES = 6'd0;

  // Wrapping increments; anything at or past the limit lands on 0.
  function automatic logic [4:0] inc_hours(input logic [4:0] h);
    return (h >= MAX_HOURS) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] inc_minutes(input logic [5:0] m);
    return (m >= MAX_MINUTES) ? 6'd0 : m + 6'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, counting debouncer, registered press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      // Any sample agreeing with the current level restarts the stability count.
      if (r_sync2 != r_level) begin
        if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/alarm_set_ctrl.sv
// Alarm time setting controller: mode/inc buttons edit a shadow time that is
// committed to the alarm registers on leaving SET_M, with auto-repeat and idle timeout.
module alarm_set_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned REPEAT_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic [4:0] edit_hours,
  output logic [5:0] edit_minutes,
  output logic [1:0] set_mode,
  output logic       commit
);

  localparam int unsigned HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HW   = $clog2(HMAX + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);

  logic w_mode_press;
  logic w_unused_mode_level;
  logic w_inc_press;
  logic w_inc_level;
  logic w_in_set;
  logic w_rep_tick;
  logic w_inc_evt;
  logic w_timeout;

  state_t        r_state;
  logic [4:0]    r_alarm_h;
  logic [5:0]    r_alarm_m;
  logic [4:0]    r_edit_h;
  logic [5:0]    r_edit_m;
  logic          r_commit;
  logic          r_rep_armed;
  logic          r_rep_phase;
  logic [HW-1:0] r_rep_cnt;
  logic [TW-1:0] r_to_cnt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (btn_mode),
    .o_level (w_unused_mode_level),
    .o_press (w_mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (btn_inc),
    .o_level (w_inc_level),
    .o_press (w_inc_press)
  );

  always_comb begin
    w_in_set   = (r_state != IDLE);
    w_rep_tick = 1'b0;
    if (r_rep_armed && w_inc_level) begin
      w_rep_tick = r_rep_phase ? (r_rep_cnt == HW'(REPEAT_CYCLES - 1))
                               : (r_rep_cnt == HW'(HOLD_CYCLES - 1));
    end
    w_inc_evt = w_in_set && (w_inc_press || w_rep_tick);
    w_timeout = (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_alarm_h   <= RST_ALARM_HOURS;
      r_alarm_m   <= RST_ALARM_MINUTES;
      r_edit_h    <= RST_ALARM_HOURS;
      r_edit_m    <= RST_ALARM_MINUTES;
      r_commit    <= 1'b0;
      r_rep_armed <= 1'b0;
      r_rep_phase <= 1'b0;
      r_rep_cnt   <= '0;
      r_to_cnt    <= '0;
    end else begin
      r_commit <= 1'b0;

      // Repeat is armed only by a press accepted in a set state; a level that
      // was already high when entering SET_H never starts repeating.
      if (!w_inc_level || !w_in_set || w_mode_press) begin
        r_rep_armed <= 1'b0;
        r_rep_phase <= 1'b0;
        r_rep_cnt   <= '0;
      end else if (w_inc_press) begin
        r_rep_armed <= 1'b1;
        r_rep_phase <= 1'b0;
        r_rep_cnt   <= '0;
      end else if (w_rep_tick) begin
        r_rep_phase <= 1'b1;
        r_rep_cnt   <= '0;
      end else if (r_rep_armed) begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end

      if (!w_in_set || w_mode_press || w_inc_evt) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      case (r_state)
        IDLE: begin
          r_edit_h <= r_alarm_h;
          r_edit_m <= r_alarm_m;
          if (w_mode_press) r_state <= SET_H;
        end
        SET_H: begin
          if (w_mode_press) begin
            r_state <= SET_M;
          end else if (w_inc_evt) begin
            r_edit_h <= inc_hours(r_edit_h);
          end else if (w_timeout) begin
            r_state  <= IDLE;
            r_edit_h <= r_alarm_h;
            r_edit_m <= r_alarm_m;
          end
        end
        SET_M: begin
          if (w_mode_press) begin
            r_state   <= IDLE;
            r_alarm_h <= r_edit_h;
            r_alarm_m <= r_edit_m;
            r_commit  <= 1'b1;
          end else if (w_inc_evt) begin
            r_edit_m <= inc_minutes(r_edit_m);
          end else if (w_timeout) begin
            r_state  <= IDLE;
            r_edit_h <= r_alarm_h;
            r_edit_m <= r_alarm_m;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign alarm_hours   = r_alarm_h;
  assign alarm_minutes = r_alarm_m;
  assign edit_hours    = r_edit_h;
  assign edit_minutes  = r_edit_m;
  assign set_mode      = r_state;
  assign commit        = r_commit;

endmodule
